// File: rtl/mtm_codeload_pkg.sv
// -----------------------------------------------------------------------------
// mtm_codeload_pkg
// Shared definitions for the boot-time code loader:
//   - state_t        : loader FSM states
//   - BYTES_PER_WORD : data bytes per 32-bit code word (little-endian)
//   - LAST_BYTE_IDX  : byte-counter value of the final byte of a word
//   - CSUM_INIT      : checksum accumulator start value
//   - csum_update()  : running XOR checksum over every frame byte
// -----------------------------------------------------------------------------
package mtm_codeload_pkg;

    typedef enum logic [2:0] {
        SAMPLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [1:0] LAST_BYTE_IDX  = 2'(BYTES_PER_WORD - 1);
    localparam logic [7:0] CSUM_INIT      = 8'h00;

    function automatic logic [7:0] csum_update(input logic [7:0] acc,
                                               input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/mtm_codeload_ctrl_word_asm.sv
// -----------------------------------------------------------------------------
// mtm_codeload_ctrl_word_asm
// Byte-to-word assembler. Bytes arrive least-significant first and are
// shifted in from the top, so after four bytes the first one sits in [7:0].
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   byte_vld       : accept byte_data this cycle
//   byte_data[7:0] : incoming byte
//   byte_cnt[1:0]  : index of the next byte within the current word
//   word[31:0]     : assembled word, meaningful while word_vld is high
//   word_vld       : one-cycle strobe, the cycle after the 4th byte
// -----------------------------------------------------------------------------
module mtm_codeload_ctrl_word_asm
    import mtm_codeload_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_vld,
    input  logic [7:0]  byte_data,
    output logic [1:0]  byte_cnt,
    output logic [31:0] word,
    output logic        word_vld
);

    // Control: byte counter and completion strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= 2'd0;
            word_vld <= 1'b0;
        end else begin
            word_vld <= byte_vld && (byte_cnt == LAST_BYTE_IDX);
            if (byte_vld) begin
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

    // Data: shift register, left unreset; consumers gate it with word_vld
    always_ff @(posedge clk) begin
        if (byte_vld) begin
            word <= {byte_data, word[31:8]};
        end
    end

endmodule

// File: rtl/mtm_codeload_ctrl.sv
// -----------------------------------------------------------------------------
// mtm_codeload_ctrl
// Boot-time code loader and code-RAM port arbiter. Holds the core in reset,
// receives LEN_LO, LEN_HI, 4*LEN data bytes and an XOR checksum byte from the
// UART, writes the words to code RAM, then hands the RAM port to the core and
// releases core reset. skip_codeload bypasses loading.
// Optional build macro: CODELOAD_TIMEOUT_EN enables an inter-byte timeout
// of TIMEOUT_CYCLES idle cycles in LEN1/DATA/CSUM.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   skip_codeload              : strap, sampled on the first edge after reset
//   rx_data_valid/rx_data      : UART byte strobe and data
//   rx_error                   : UART framing error strobe
//   core_ram_ce/we/addr/wdata  : core-side RAM request
//   ram_ce/we/addr/wdata       : RAM port (loader before DONE, core after)
//   core_rst_n                 : registered core reset, active low
//   load_done                  : RAM owned by the core
//   load_error                 : sticky load failure
//   words_loaded               : number of words written by the loader
// -----------------------------------------------------------------------------
module mtm_codeload_ctrl
    import mtm_codeload_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int DEPTH          = 4096,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              skip_codeload,
    input  logic              rx_data_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_error,
    input  logic              core_ram_ce,
    input  logic              core_ram_we,
    input  logic [ADDR_W-1:0] core_ram_addr,
    input  logic [31:0]       core_ram_wdata,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              core_rst_n,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    if (DEPTH < 1 || DEPTH > (1 << ADDR_W) || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mtm_codeload_ctrl: DEPTH must be 1..2**ADDR_W and TIMEOUT_CYCLES >= 1");
    end

    state_t      state;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [7:0]  acc;

    logic        byte_vld;
    logic [1:0]  byte_cnt;
    logic [31:0] word;
    logic        word_vld;
    logic        last_word;
    logic [15:0] len_rx;
    logic        timed_out;

    assign byte_vld  = (state == DATA) && rx_data_valid && !rx_error;
    assign len_rx    = {rx_data, len_lo};
    // The word being completed is always words_loaded: the previous write has
    // retired at least three cycles before the next word's final byte.
    assign last_word = (32'(words_loaded) == 32'(len) - 32'd1);

    mtm_codeload_ctrl_word_asm u_word_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_vld  (byte_vld),
        .byte_data (rx_data),
        .byte_cnt  (byte_cnt),
        .word      (word),
        .word_vld  (word_vld)
    );

`ifdef CODELOAD_TIMEOUT_EN
    logic [31:0] to_cnt;

    // Idle-cycle counter; cleared by every byte and while leaving SAMPLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= 32'd0;
        end else if (rx_data_valid || state == SAMPLE) begin
            to_cnt <= 32'd0;
        end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + 32'd1;
        end
    end

    assign timed_out = (state inside {LEN1, DATA, CSUM}) && !rx_data_valid &&
                       (to_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    // Loader FSM with registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SAMPLE;
            len_lo       <= 8'd0;
            len          <= 16'd0;
            acc          <= CSUM_INIT;
            words_loaded <= '0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            core_rst_n   <= 1'b0;
        end else begin
            load_done  <= (state == DONE);
            core_rst_n <= (state == DONE);
            load_error <= (state == ERROR);

            if (word_vld) begin
                words_loaded <= words_loaded + 1'b1;
            end

            case (state)
                SAMPLE: state <= skip_codeload ? DONE : LEN0;
                LEN0: begin
                    if (rx_error) begin
                        state <= ERROR;
                    end else if (rx_data_valid) begin
                        len_lo <= rx_data;
                        acc    <= csum_update(acc, rx_data);
                        state  <= LEN1;
                    end
                end
                LEN1: begin
                    if (rx_error) begin
                        state <= ERROR;
                    end else if (rx_data_valid) begin
                        len <= len_rx;
                        acc <= csum_update(acc, rx_data);
                        if (32'(len_rx) > 32'(DEPTH)) begin
                            state <= ERROR;
                        end else if (len_rx == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (rx_error) begin
                        state <= ERROR;
                    end else if (rx_data_valid) begin
                        acc <= csum_update(acc, rx_data);
                        // Leave on the final byte so a checksum byte arriving
                        // back-to-back during the RAM write is not missed.
                        if (byte_cnt == LAST_BYTE_IDX && last_word) begin
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (rx_error) begin
                        state <= ERROR;
                    end else if (rx_data_valid) begin
                        state <= (rx_data == acc) ? DONE : ERROR;
                    end
                end
                default: state <= state;
            endcase

            if (timed_out) begin
                state <= ERROR;
            end
        end
    end

    // RAM port: loader write strobe before DONE, combinational core path after
    always_comb begin
        if (load_done) begin
            ram_ce    = core_ram_ce;
            ram_we    = core_ram_we;
            ram_addr  = core_ram_addr;
            ram_wdata = core_ram_wdata;
        end else begin
            ram_ce    = word_vld;
            ram_we    = word_vld;
            ram_addr  = word_vld ? words_loaded[ADDR_W-1:0] : '0;
            ram_wdata = word_vld ? word : 32'd0;
        end
    end

endmodule

// File: tb/tb_mtm_codeload_ctrl.sv
module tb_mtm_codeload_ctrl;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4096;
    localparam int TMO    = 100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              skip_codeload = 1'b0;
    logic              rx_data_valid = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_error = 1'b0;
    logic              core_ram_ce = 1'b0;
    logic              core_ram_we = 1'b0;
    logic [ADDR_W-1:0] core_ram_addr = '0;
    logic [31:0]       core_ram_wdata = 32'd0;
    logic              ram_ce, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              core_rst_n, load_done, load_error;
    logic [ADDR_W:0]   words_loaded;

    int tests = 0;
    int fails = 0;

    // expected loader writes, in order, and the RAM contents they produce
    logic [ADDR_W-1:0] exp_wa[$];
    logic [31:0]       exp_wd[$];
    logic [31:0]       mem[0:15];

    mtm_codeload_ctrl #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .skip_codeload(skip_codeload),
        .rx_data_valid(rx_data_valid), .rx_data(rx_data), .rx_error(rx_error),
        .core_ram_ce(core_ram_ce), .core_ram_we(core_ram_we),
        .core_ram_addr(core_ram_addr), .core_ram_wdata(core_ram_wdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .core_rst_n(core_rst_n), .load_done(load_done), .load_error(load_error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Core side keeps issuing random requests the whole time
    initial begin
        forever begin
            @(posedge clk);
            #2;
            core_ram_ce    = 1'($urandom_range(1, 0));
            core_ram_we    = 1'($urandom_range(1, 0));
            core_ram_addr  = ADDR_W'($urandom);
            core_ram_wdata = $urandom;
        end
    end

    // Per-cycle compare against the expected write list and ownership rules
    always @(negedge clk) begin
        if (rst_n) begin
            chk("core_rst_n_eq_done", 64'(core_rst_n), 64'(load_done));
            if (load_done) begin
                chk("passthru", 64'({ram_ce, ram_we, ram_addr, ram_wdata}),
                    64'({core_ram_ce, core_ram_we, core_ram_addr, core_ram_wdata}));
            end else if (ram_ce) begin
                chk("wr_expected", 64'(exp_wa.size() > 0), 64'(1));
                if (exp_wa.size() > 0) begin
                    chk("wr_addr_data", 64'({ram_we, ram_addr, ram_wdata}),
                        64'({1'b1, exp_wa[0], exp_wd[0]}));
                    void'(exp_wa.pop_front());
                    void'(exp_wd.pop_front());
                end
                if (ram_addr < 16) mem[ram_addr[3:0]] = ram_wdata;
            end
            if (load_error) chk("err_ram_idle", 64'({ram_ce, ram_we, load_done}), 64'(0));
        end
    end

    // Spec-level frame model: expected writes and final outcome
    task automatic model_frame(input logic [7:0] fb[$], output logic edone,
                               output logic eerr, output int ew);
        int len;
        logic [7:0] acc;
        len = int'({fb[1], fb[0]});
        acc = fb[0] ^ fb[1];
        ew = 0;
        if (len > DEPTH) begin
            edone = 1'b0;
            eerr  = 1'b1;
            return;
        end
        for (int w = 0; w < len; w++) begin
            exp_wa.push_back(ADDR_W'(w));
            exp_wd.push_back({fb[2+4*w+3], fb[2+4*w+2], fb[2+4*w+1], fb[2+4*w]});
            for (int k = 0; k < 4; k++) acc = acc ^ fb[2+4*w+k];
            ew++;
        end
        edone = (fb[2+4*len] == acc);
        eerr  = !edone;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_valid = 1'b1;
        rx_data = b;
        @(posedge clk);
        #1;
        rx_data_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] fb[$]);
        foreach (fb[i]) send_byte(fb[i]);
    endtask

    task automatic do_reset(input logic skip);
        skip_codeload = skip;
        rx_data_valid = 1'b0;
        rx_error = 1'b0;
        rst_n = 1'b0;
        #3;
        chk("reset_vals", 64'({ram_ce, ram_we, ram_addr, ram_wdata, core_rst_n,
                               load_done, load_error, words_loaded}), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (!(load_done || load_error) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_result(input string tag, input logic edone,
                                input logic eerr, input int ew);
        chk({tag, "_done"}, 64'(load_done), 64'(edone));
        chk({tag, "_error"}, 64'(load_error), 64'(eerr));
        chk({tag, "_core_rst_n"}, 64'(core_rst_n), 64'(edone));
        chk({tag, "_words"}, 64'(words_loaded), 64'(ew));
        chk({tag, "_writes_left"}, 64'(exp_wa.size()), 64'(0));
    endtask

    initial begin
        logic [7:0] f[$];
        logic [7:0] good[$];
        logic edone, eerr;
        int ew;

        good = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7E};

        // skip strap: done within two cycles, pass-through, no writes
        do_reset(1'b1);
        chk("skip_done_early", 64'(load_done), 64'(0));
        @(posedge clk);
        #1;
        chk("skip_done", 64'({load_done, core_rst_n}), 64'(2'b11));
        repeat (10) @(posedge clk);
        #1;
        check_result("skip", 1'b1, 1'b0, 0);

        // two-word frame, good checksum
        do_reset(1'b0);
        model_frame(good, edone, eerr, ew);
        chk("model_good_done", 64'(edone), 64'(1));
        send_frame(good);
        settle();
        check_result("good", edone, eerr, ew);
        chk("good_ram0", 64'(mem[0]), 64'(32'h00000013));
        chk("good_ram1", 64'(mem[1]), 64'(32'h0000006F));
        repeat (10) @(posedge clk);
        #1;

        // same frame, bad checksum
        do_reset(1'b0);
        mem[0] = 32'd0;
        mem[1] = 32'd0;
        f = good;
        f[10] = 8'h7F;
        model_frame(f, edone, eerr, ew);
        send_frame(f);
        settle();
        check_result("badcsum", edone, eerr, ew);
        chk("badcsum_ram1", 64'(mem[1]), 64'(32'h0000006F));
        repeat (10) @(posedge clk);
        #1;

        // three words, little-endian assembly
        do_reset(1'b0);
        f = '{8'h03, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
              8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
        f[14] = 8'h03 ^ 8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12 ^ 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE
                ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04;
        model_frame(f, edone, eerr, ew);
        send_frame(f);
        settle();
        check_result("three", edone, eerr, ew);
        chk("three_ram0", 64'(mem[0]), 64'(32'h12345678));
        chk("three_ram2", 64'(mem[2]), 64'(32'h04030201));

        // empty frame
        do_reset(1'b0);
        f = '{8'h00, 8'h00, 8'h00};
        model_frame(f, edone, eerr, ew);
        send_frame(f);
        settle();
        check_result("len0", edone, eerr, ew);

        // LEN = 4097 exceeds DEPTH
        do_reset(1'b0);
        f = '{8'h01, 8'h10};
        model_frame(f, edone, eerr, ew);
        send_frame(f);
        @(posedge clk);
        #1;
        chk("lenovf_err_fast", 64'(load_error), 64'(1));
        send_frame('{8'h13, 8'h00, 8'h00, 8'h00, 8'h13});
        settle();
        check_result("lenovf", edone, eerr, ew);

        // rx_error together with the 3rd data byte of word 0
        do_reset(1'b0);
        send_frame('{8'h02, 8'h00, 8'h13, 8'h00});
        rx_error = 1'b1;
        send_byte(8'h00);
        rx_error = 1'b0;
        send_frame('{8'h00, 8'h6F});
        settle();
        check_result("rxerr", 1'b0, 1'b1, 0);

        // reset mid-frame after one word, then a clean reload
        do_reset(1'b0);
        exp_wa.push_back('0);
        exp_wd.push_back(32'h00000013);
        send_frame('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F});
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_words", 64'(words_loaded), 64'(1));
        do_reset(1'b0);
        model_frame(good, edone, eerr, ew);
        send_frame(good);
        settle();
        check_result("reload", edone, eerr, ew);

        // stall of TMO idle cycles after the first data byte
        do_reset(1'b0);
        send_frame('{8'h02, 8'h00, 8'h13});
        repeat (TMO) @(posedge clk);
        #1;
`ifdef CODELOAD_TIMEOUT_EN
        chk("stall_timeout", 64'(load_error), 64'(0));
        @(posedge clk);
        #1;
        chk("stall_timeout_err", 64'(load_error), 64'(1));
        send_frame('{8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7E});
        settle();
        check_result("stall", 1'b0, 1'b1, 0);
`else
        model_frame(good, edone, eerr, ew);
        send_frame('{8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7E});
        settle();
        check_result("stall", edone, eerr, ew);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mtm_codeload_ctrl.md
Name: mtm_codeload_ctrl

Overview:
- Boot-time code loader and code-RAM port arbiter for the SoC.
- Holds the core in reset and receives a program image byte-by-byte from the UART receiver.
- Assembles the bytes into 32-bit little-endian words and writes them into code RAM.
- After a successful checksum, hands the RAM port over to the core and releases core reset.
- A skip strap (gpio_din[3] at chip level) bypasses loading entirely.

Parameters:
- ADDR_W, 12, code RAM word-address width (4096 words).
- DEPTH, 4096, maximum loadable words; must satisfy DEPTH <= 2**ADDR_W.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout; used only with CODELOAD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- skip_codeload  in  1  strap; sampled once, on the first clk edge after rst_n rises.
- rx_data_valid  in  1  one-cycle strobe from the UART receiver.
- rx_data  in  8  received byte; valid with rx_data_valid.
- rx_error  in  1  UART framing error strobe.
- core_ram_ce  in  1  core-side RAM chip enable.
- core_ram_we  in  1  core-side RAM write enable.
- core_ram_addr  in  ADDR_W  core-side RAM word address.
- core_ram_wdata  in  32  core-side RAM write data.
- ram_ce  out  1  RAM chip enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wdata  out  32  RAM write data.
- core_rst_n  out  1  registered core reset, active low.
- load_done  out  1  RAM owned by the core.
- load_error  out  1  sticky load failure.
- words_loaded  out  ADDR_W+1  count of words written.

Behaviour:
- Reset values:
  - ram_ce=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - core_rst_n=0, load_done=0, load_error=0, words_loaded=0.
  - state=SAMPLE; checksum accumulator=0.
- Frame format: LEN_LO, LEN_HI (length in words), then 4*LEN data bytes (little-endian per word), then CSUM.
  - CSUM = XOR of every preceding byte, including both length bytes.
- FSM:
  - SAMPLE: first cycle after reset. skip_codeload=1 -> DONE; otherwise -> LEN0.
  - LEN0: on rx byte, store it as the length low byte -> LEN1.
  - LEN1: on rx byte, form LEN.
    - LEN > DEPTH -> ERROR.
    - LEN == 0 -> CSUM.
    - otherwise -> DATA.
  - DATA: shift each byte into the word register; a 2-bit byte counter wraps 3->0.
    - On the 4th byte, the next cycle drives ram_ce=1, ram_we=1, ram_addr=words_loaded, ram_wdata=word for exactly one cycle, then increments words_loaded.
    - After word LEN-1 is written -> CSUM.
  - CSUM: on rx byte, equal to accumulator -> DONE; otherwise -> ERROR.
  - DONE: load_done=1 and core_rst_n=1, both registered (rise one cycle after DONE is entered). Absorbing until rst_n.
  - ERROR: load_error=1, core_rst_n stays 0, RAM outputs idle. Absorbing until rst_n.
- Error and ignore rules:
  - rx_error in LEN0, LEN1, DATA or CSUM -> ERROR, also when it coincides with rx_data_valid.
  - rx bytes in DONE or ERROR are ignored.
- RAM mux:
  - Outside DONE, the loader owns the port and core_ram_* inputs are ignored.
  - In DONE, ram_* = core_ram_* combinationally (no added latency).
  - The mux select is registered; ownership switches in the same cycle load_done rises.
- Asynchronous reset mid-load: all state clears, RAM outputs go idle immediately, and partial RAM contents are not cleared. The next frame starts from LEN0.
- Byte arrival: back-to-back rx_data_valid on consecutive cycles is legal; the write pipeline must not drop bytes.

Optional Feature:
- CODELOAD_TIMEOUT_EN defined:
  - A counter resets on every rx_data_valid and on entry to LEN0.
  - If it reaches TIMEOUT_CYCLES while in LEN1, DATA or CSUM -> ERROR.
  - LEN0 waits forever.
- Undefined: no counter and no timeout; the FSM waits indefinitely in every state.

Decomposition:
- Shared package mtm_codeload_pkg holds:
  - the state enum (SAMPLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR);
  - the frame-field constants;
  - the checksum function.
- Sub-module mtm_codeload_word_asm: byte-to-word shifter plus byte counter, emitting a one-cycle word_valid.
- FSM and RAM mux stay in the top module.

Test Plan:
- skip_codeload=1 at reset -> load_done=1 and core_rst_n=1 within 2 cycles; core_ram_* passes through; no RAM writes.
- Frame 02 00 | 13 00 00 00 | 6F 00 00 00 | CSUM=7E -> RAM[0]=0x00000013, RAM[1]=0x0000006F; words_loaded=2; load_done=1; core_rst_n=1.
- Same frame with CSUM=7F -> load_error=1; core_rst_n stays 0; RAM[0..1] written; ram_* ignores core_ram_*.
- Frame 01 10 (LEN=4097 > DEPTH) -> ERROR right after the second byte; no RAM write.
- rx_error pulse on the 3rd data byte of word 0 -> ERROR; no RAM write. Assert rst_n mid-frame, resend a valid frame -> loads correctly.
- With CODELOAD_TIMEOUT_EN and TIMEOUT_CYCLES=100: send 02 00 13, then stall 100 cycles -> load_error=1. Without the macro, the same stall followed by the remaining bytes -> load_done=1.
